sram_control: RTL and testbench

//  Controller for an asynchronous-mode CellularRAM-style SRAM. Takes one-shot write/read

---
 rtl/sram_ctrl_pkg.sv | 18 +
 rtl/sram_control.sv | 142 ++++++++++++++
 tb/tb_sram_control.sv | 225 ++++++++++++++++++++++
 3 files changed

// File: rtl/sram_ctrl_pkg.sv
// Shared definitions for the CellularRAM-style SRAM controller.
// Holds the FSM state encoding (also exported on the debug state port)
// and the default widths / strobe cycle counts.
package sram_ctrl_pkg;

  typedef enum logic [1:0] {
    StIdle  = 2'b00,
    StWrite = 2'b01,
    StRead  = 2'b10,
    StHold  = 2'b11
  } state_e;

  localparam int unsigned DefDataW    = 4;
  localparam int unsigned DefAddrW    = 4;
  localparam int unsigned DefWrCycles = 2;
  localparam int unsigned DefRdCycles = 2;

endpackage

// File: rtl/sram_control.sv
// Controller for an asynchronous-mode CellularRAM-style SRAM.
// Accepts one-shot write/read requests (rising edges) while idle, then
// sequences ce/we/oe around the shared bidirectional data bus.
// Ports:
//   clk, rst            clock (rising edge), async active-low reset
//   data_in, address_in request data/address, captured when accepted
//   write, read         request strobes, rising-edge sensitive
//   sram_data           bidirectional SRAM data bus
//   data_out            last read data, held until the next read completes
//   address_out         registered SRAM address
//   ce, we, oe          registered active-low SRAM enables
//   sram_clk, adv, cre, lb, ub  tied low (async mode, full-word array access)
//   state               FSM state for debug
module sram_control
  import sram_ctrl_pkg::*;
#(
  parameter int unsigned DATA_W    = DefDataW,
  parameter int unsigned ADDR_W    = DefAddrW,
  parameter int unsigned WR_CYCLES = DefWrCycles,
  parameter int unsigned RD_CYCLES = DefRdCycles
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [DATA_W-1:0] data_in,
  input  logic [ADDR_W-1:0] address_in,
  input  logic              write,
  input  logic              read,
  inout  wire  [DATA_W-1:0] sram_data,
  output logic [DATA_W-1:0] data_out,
  output logic [ADDR_W-1:0] address_out,
  output logic              ce,
  output logic              we,
  output logic              oe,
  output logic              sram_clk,
  output logic              adv,
  output logic              cre,
  output logic              lb,
  output logic              ub,
  output logic [1:0]        state
);

  localparam int unsigned MaxCyc = (WR_CYCLES > RD_CYCLES) ? WR_CYCLES : RD_CYCLES;
  localparam int unsigned CntW   = (MaxCyc > 1) ? $clog2(MaxCyc) : 1;

  state_e              state_q, state_d;
  logic [CntW-1:0]     cnt_q, cnt_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [DATA_W-1:0]   wdata_q, wdata_d;
  logic [DATA_W-1:0]   dout_q, dout_d;
  logic                wr_q, rd_q;
  logic                ce_q, we_q, oe_q;
  logic                ce_d, we_d, oe_d;
  logic                wr_req, rd_req;

  assign wr_req = write & ~wr_q;
  assign rd_req = read & ~rd_q;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    dout_d  = dout_q;
    unique case (state_q)
      StIdle: begin
        // Write has priority; a simultaneous read edge is simply lost.
        if (wr_req) begin
          state_d = StWrite;
          cnt_d   = CntW'(WR_CYCLES - 1);
          addr_d  = address_in;
          wdata_d = data_in;
        end else if (rd_req) begin
          state_d = StRead;
          cnt_d   = CntW'(RD_CYCLES - 1);
          addr_d  = address_in;
          wdata_d = data_in;
        end
      end
      StWrite: begin
        if (cnt_q == '0) state_d = StHold;
        else             cnt_d   = cnt_q - 1'b1;
      end
      StRead: begin
        if (cnt_q == '0) begin
          dout_d  = sram_data;
          state_d = StHold;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      StHold: state_d = StIdle;
    endcase

    // Strobes are registered from the next state so they track state_q exactly.
    ce_d = ~((state_d == StWrite) || (state_d == StRead));
    we_d = ~(state_d == StWrite);
    oe_d = ~(state_d == StRead);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      addr_q  <= '0;
      wdata_q <= '0;
      dout_q  <= '0;
      wr_q    <= 1'b0;
      rd_q    <= 1'b0;
      ce_q    <= 1'b1;
      we_q    <= 1'b1;
      oe_q    <= 1'b1;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      dout_q  <= dout_d;
      wr_q    <= write;
      rd_q    <= read;
      ce_q    <= ce_d;
      we_q    <= we_d;
      oe_q    <= oe_d;
    end
  end

  // Bus enable keyed off the we register: it is low only in WRITE, where oe is
  // high, and the async reset releases the bus immediately.
  assign sram_data = we_q ? {DATA_W{1'bz}} : wdata_q;

  assign data_out    = dout_q;
  assign address_out = addr_q;
  assign ce          = ce_q;
  assign we          = we_q;
  assign oe          = oe_q;
  assign state       = state_q;
  assign sram_clk    = 1'b0;
  assign adv         = 1'b0;
  assign cre         = 1'b0;
  assign lb          = 1'b0;
  assign ub          = 1'b0;

endmodule

// File: tb/tb_sram_control.sv
// Directed self-checking bench for sram_control with an inline behavioural
// 16x4 SRAM model (drives the bus when ce=0 & oe=0, writes on we rising).
module tb_sram_control;

  logic       clk;
  logic       rst;
  logic [3:0] data_in;
  logic [3:0] address_in;
  logic       write;
  logic       read;
  wire  [3:0] sram_data;
  logic [3:0] data_out;
  logic [3:0] address_out;
  logic       ce, we, oe, sram_clk, adv, cre, lb, ub;
  logic [1:0] state;

  int n_checks;
  int n_errors;

  sram_control dut (
    .clk         (clk),
    .rst         (rst),
    .data_in     (data_in),
    .address_in  (address_in),
    .write       (write),
    .read        (read),
    .sram_data   (sram_data),
    .data_out    (data_out),
    .address_out (address_out),
    .ce          (ce),
    .we          (we),
    .oe          (oe),
    .sram_clk    (sram_clk),
    .adv         (adv),
    .cre         (cre),
    .lb          (lb),
    .ub          (ub),
    .state       (state)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // SRAM model
  logic [3:0] mem [16];
  logic [3:0] wr_addr_lat;
  logic [3:0] wr_data_lat;
  logic       wr_pending;
  int         n_mem_writes;

  assign sram_data = (!ce && !oe) ? mem[address_out] : 4'bzzzz;

  initial begin
    for (int i = 0; i < 16; i++) mem[i] = 4'h0;
    wr_pending   = 1'b0;
    n_mem_writes = 0;
  end

  // Latch write address/data mid-cycle while the write strobe is active.
  always @(negedge clk) begin
    if (!ce && !we) begin
      wr_addr_lat = address_out;
      wr_data_lat = sram_data;
      wr_pending  = 1'b1;
    end
  end

  always @(posedge we) begin
    if (wr_pending) begin
      mem[wr_addr_lat] = wr_data_lat;
      n_mem_writes     = n_mem_writes + 1;
      wr_pending       = 1'b0;
    end
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_write(input logic [3:0] addr, input logic [3:0] data);
    @(negedge clk);
    address_in = addr;
    data_in    = data;
    write      = 1'b1;
    tick();
    check_eq("wr_state1", {30'b0, state}, 32'h1);
    check_eq("wr_strobes1", {29'b0, ce, we, oe}, 32'b001);
    check_eq("wr_bus", {28'b0, sram_data}, {28'b0, data});
    check_eq("wr_addr", {28'b0, address_out}, {28'b0, addr});
    @(negedge clk);
    write = 1'b0;
    tick();
    check_eq("wr_state2", {30'b0, state}, 32'h1);
    check_eq("wr_we2", {31'b0, we}, 32'h0);
    tick();
    check_eq("wr_hold", {30'b0, state}, 32'h3);
    check_eq("wr_hold_strobes", {29'b0, ce, we, oe}, 32'b111);
    tick();
    check_eq("wr_idle", {30'b0, state}, 32'h0);
  endtask

  task automatic do_read(input logic [3:0] addr, input logic [3:0] exp, input logic [3:0] prev);
    @(negedge clk);
    address_in = addr;
    data_in    = 4'hf;
    read       = 1'b1;
    tick();
    check_eq("rd_state1", {30'b0, state}, 32'h2);
    check_eq("rd_strobes1", {29'b0, ce, we, oe}, 32'b010);
    check_eq("rd_dout_held", {28'b0, data_out}, {28'b0, prev});
    @(negedge clk);
    read = 1'b0;
    tick();
    check_eq("rd_state2", {30'b0, state}, 32'h2);
    check_eq("rd_bus", {28'b0, sram_data}, {28'b0, exp});
    tick();
    check_eq("rd_hold", {30'b0, state}, 32'h3);
    check_eq("rd_dout", {28'b0, data_out}, {28'b0, exp});
    tick();
    check_eq("rd_idle", {30'b0, state}, 32'h0);
    check_eq("rd_dout_idle", {28'b0, data_out}, {28'b0, exp});
  endtask

  initial begin
    n_checks   = 0;
    n_errors   = 0;
    rst        = 1'b0;
    write      = 1'b0;
    read       = 1'b0;
    data_in    = 4'h0;
    address_in = 4'h0;

    // 1. reset state
    repeat (3) @(posedge clk);
    #1;
    check_eq("rst_strobes", {29'b0, ce, we, oe}, 32'b111);
    check_eq("rst_state", {30'b0, state}, 32'h0);
    @(negedge clk);
    rst = 1'b1;
    tick();
    check_eq("rel_strobes", {29'b0, ce, we, oe}, 32'b111);
    check_eq("rel_state", {30'b0, state}, 32'h0);
    check_eq("rel_dout", {28'b0, data_out}, 32'h0);
    check_eq("rel_addr", {28'b0, address_out}, 32'h0);
    check_eq("rel_consts", {27'b0, adv, cre, lb, ub, sram_clk}, 32'h0);

    // 2. writes
    for (int n = 1; n <= 4; n++) do_write(4'(n), 4'(n));
    for (int n = 1; n <= 4; n++) check_eq("mem_after_wr", {28'b0, mem[n]}, n);
    check_eq("wr_count", n_mem_writes, 4);

    // 3. reads
    for (int n = 1; n <= 4; n++) do_read(4'(n), 4'(n), 4'(n - 1));
    repeat (3) tick();
    check_eq("dout_held", {28'b0, data_out}, 32'h4);

    // 4. simultaneous write/read edge: write wins
    @(negedge clk);
    address_in = 4'h5;
    data_in    = 4'h9;
    write      = 1'b1;
    read       = 1'b1;
    tick();
    check_eq("sim_state", {30'b0, state}, 32'h1);
    @(negedge clk);
    write = 1'b0;
    read  = 1'b0;
    repeat (4) tick();
    check_eq("sim_idle", {30'b0, state}, 32'h0);
    check_eq("sim_mem5", {28'b0, mem[5]}, 32'h9);
    check_eq("sim_no_read", {28'b0, data_out}, 32'h4);
    check_eq("sim_count", n_mem_writes, 5);
    do_read(4'h5, 4'h9, 4'h4);

    // 5. write held high, plus a second edge during WRITE
    @(negedge clk);
    address_in = 4'h6;
    data_in    = 4'h7;
    write      = 1'b1;
    tick();
    check_eq("hold_state", {30'b0, state}, 32'h1);
    @(negedge clk);
    write = 1'b0;
    @(negedge clk);
    write = 1'b1;
    repeat (9) tick();
    @(negedge clk);
    write = 1'b0;
    repeat (3) tick();
    check_eq("hold_count", n_mem_writes, 6);
    check_eq("hold_mem6", {28'b0, mem[6]}, 32'h7);
    check_eq("hold_idle", {30'b0, state}, 32'h0);

    // 6. reset during READ
    @(negedge clk);
    address_in = 4'h2;
    read       = 1'b1;
    tick();
    check_eq("abort_pre", {30'b0, state}, 32'h2);
    rst = 1'b0;
    #1;
    check_eq("abort_strobes", {29'b0, ce, we, oe}, 32'b111);
    check_eq("abort_state", {30'b0, state}, 32'h0);
    check_eq("abort_dout", {28'b0, data_out}, 32'h0);
    @(negedge clk);
    read = 1'b0;
    rst  = 1'b1;
    repeat (3) tick();
    check_eq("abort_after", {30'b0, state}, 32'h0);
    check_eq("abort_dout_after", {28'b0, data_out}, 32'h0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
